// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared FSM encoding, key map and parameter defaults for keypad_scan
// Revision : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int SCAN_DIV_DEFAULT       = 100000;
    localparam int DEBOUNCE_TICKS_DEFAULT = 20;

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // One nibble per key, indexed by {row, col}; index 0 is the low nibble.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col, 2'b00} +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_tick_gen.sv
// ============================================================================
// Module   : keypad_tick_gen
// Brief    : Free-running prescaler producing a one-cycle scan tick
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_tick_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic clk_100mhz,
    input  logic reset,
    output logic tick
);

    localparam int              PW   = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        tick    = (presc_q == LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// Module   : keypad_scan
// Brief    : 4x4 keypad column scanner with debounce; KEYPAD_ENTRY_EN adds a
//            4-digit BCD entry register on entry_value
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
`ifdef KEYPAD_ENTRY_EN
    output logic        key_held,
    output logic [15:0] entry_value
`else
    output logic        key_held
`endif
);

    localparam int            CW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DEB_LIM = CW'(DEBOUNCE_TICKS);

    logic          tick;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    state_t        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_sel_q, row_sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [1:0]    low_row;
    logic          any_low;
    logic          row_low;

    keypad_tick_gen #(
        .SCAN_DIV   (SCAN_DIV)
    ) u_tick_gen (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .tick       (tick)
    );

    // Lowest-index active row wins when several rows are low together.
    always_comb begin
        sync1_d = row_n;
        sync2_d = sync1_q;
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!sync2_q[i]) begin
                low_row = 2'(i);
            end
        end
        any_low = ~&sync2_q;
        row_low = ~sync2_q[row_sel_q];
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            row_sel_q   <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_sel_q   <= row_sel_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_sel_d   = row_sel_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        cnt_inc     = cnt_q + CW'(1);
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        row_sel_d = low_row;
                        cnt_d     = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LIM) begin
                            key_code_d  = key_lookup(row_sel_q, col_idx_q);
                            key_valid_d = 1'b1;
                            state_d     = ST_PRESSED;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_PRESSED: begin
                    if (!row_low) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE_WAIT;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!row_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LIM) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_comb begin
        col_n     = ~(4'b0001 << col_idx_q);
        key_code  = key_code_q;
        key_valid = key_valid_q;
        key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
    end

`ifdef KEYPAD_ENTRY_EN
    logic [15:0] entry_q, entry_d;

    // Digits shift in from the right; C clears; other letters are ignored.
    always_comb begin
        entry_d = entry_q;
        if (key_valid_d) begin
            if (key_code_d <= 4'd9) begin
                entry_d = {entry_q[11:0], key_code_d};
            end else if (key_code_d == 4'hC) begin
                entry_d = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            entry_q <= 16'h0000;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_value = entry_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// Module   : tb_keypad_scan
// Brief    : Self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_TICKS=3)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk_100mhz = 1'b0;
    logic        reset      = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
`ifdef KEYPAD_ENTRY_EN
    logic [15:0] entry_value;
`endif

    logic [15:0] keys = 16'h0000;   // keys[r*4+c] = key at row r, column c held down
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_pulse = 0;
    bit          armed = 1'b0;

    always #5 clk_100mhz = ~clk_100mhz;

    keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
`ifdef KEYPAD_ENTRY_EN
        .key_held    (key_held),
        .entry_value (entry_value)
`else
        .key_held    (key_held)
`endif
    );

    // Physical keypad: a row reads low when a held key connects it to a driven-low column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference ----------------
    int          kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    int          m_pre, m_phase, m_cnt, m_col, m_row, m_code;
    bit          m_valid;
    logic [3:0]  m_s1, m_s2;
    logic [15:0] m_entry;

    function automatic logic [3:0] rows_seen(input int col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++) if (keys[i*4+col]) r[i] = 1'b0;
        return r;
    endfunction

    // m_phase: 0 scanning, 1 confirming press, 2 holding, 3 confirming release
    always @(posedge clk_100mhz or posedge reset) begin : ref_model
        logic [3:0] rs;
        logic [3:0] now_rows;
        bit         tk;
        int         lo;
        if (reset) begin
            m_pre = 0; m_phase = 0; m_cnt = 0; m_col = 0; m_row = 0; m_code = 0;
            m_valid = 1'b0; m_s1 = 4'hF; m_s2 = 4'hF; m_entry = 16'h0000;
        end else begin
            rs       = m_s2;
            now_rows = rows_seen(m_col);
            tk       = (m_pre == SD - 1);
            m_pre    = (m_pre + 1) % SD;
            m_valid  = 1'b0;
            if (tk) begin
                if (m_phase == 0) begin
                    if (rs != 4'hF) begin
                        lo = 0;
                        while (rs[lo]) lo++;
                        m_row = lo; m_cnt = 0; m_phase = 1;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end else if (m_phase == 1) begin
                    if (!rs[m_row]) begin
                        m_cnt++;
                        if (m_cnt == DT) begin
                            m_code  = kmap[m_row][m_col];
                            m_valid = 1'b1;
                            m_phase = 2;
                            if (m_code <= 9)       m_entry = {m_entry[11:0], 4'(m_code)};
                            else if (m_code == 12) m_entry = 16'h0000;
                        end
                    end else begin
                        m_phase = 0;
                        m_col   = (m_col + 1) % 4;
                    end
                end else if (m_phase == 2) begin
                    if (rs[m_row]) begin
                        m_phase = 3; m_cnt = 0;
                    end
                end else begin
                    if (rs[m_row]) begin
                        m_cnt++;
                        if (m_cnt == DT) begin
                            m_phase = 0;
                            m_col   = (m_col + 1) % 4;
                        end
                    end else begin
                        m_phase = 2;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = now_rows;
        end
    end

    always @(negedge clk_100mhz) begin : compare
        logic [3:0] ec;
        if (armed) begin
            ec = 4'hF;
            ec[m_col] = 1'b0;
            check("col_n", {12'h0, col_n}, {12'h0, ec});
            check("key_code", {12'h0, key_code}, {12'h0, 4'(m_code)});
            check("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
            check("key_held", {15'h0, key_held}, {15'h0, (m_phase >= 2)});
`ifdef KEYPAD_ENTRY_EN
            check("entry_value", entry_value, m_entry);
`endif
        end
        if (key_valid === 1'b1) n_pulse++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_100mhz);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
    endtask

`ifdef KEYPAD_ENTRY_EN
    task automatic press_key(input int r, input int c);
        keys = 16'h0000;
        keys[r*4+c] = 1'b1;
        cyc(100);
        keys = 16'h0000;
        cyc(40);
    endtask
`endif

    initial begin : stim
        int          p0;
        logic [3:0]  steps [4];
        steps[0] = 4'b1101; steps[1] = 4'b1011; steps[2] = 4'b0111; steps[3] = 4'b1110;

        cyc(1);
        armed = 1'b1;

        // Reset values and free-running column walk
        reset = 1'b1;
        cyc(3);
        check("rst_col_n", {12'h0, col_n}, 16'h000E);
        check("rst_valid", {15'h0, key_valid}, 16'h0);
        check("rst_held", {15'h0, key_held}, 16'h0);
        check("rst_code", {12'h0, key_code}, 16'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(SD);
            check("col_step", {12'h0, col_n}, {12'h0, steps[k]});
        end

        // Stable press of row1/col2 then release
        do_reset();
        p0 = n_pulse;
        keys[1*4+2] = 1'b1;
        cyc(40);
        check("k6_pulses", 16'(n_pulse - p0), 16'd1);
        check("k6_code", {12'h0, key_code}, 16'h0006);
        check("k6_held", {15'h0, key_held}, 16'h1);
        keys = 16'h0000;
        cyc(28);
        check("k6_release", {15'h0, key_held}, 16'h0);

        // One-tick bounce on row0/col0
        do_reset();
        p0 = n_pulse;
        keys[0] = 1'b1;
        cyc(4);
        keys = 16'h0000;
        cyc(4);
        check("bounce_col", {12'h0, col_n}, 16'h000D);
        cyc(20);
        check("bounce_pulses", 16'(n_pulse - p0), 16'd0);

        // Rows 0 and 2 on column 0: lowest row wins, no repeat on partial release
        do_reset();
        p0 = n_pulse;
        keys[0*4+0] = 1'b1;
        keys[2*4+0] = 1'b1;
        cyc(24);
        check("dual_code", {12'h0, key_code}, 16'h0001);
        check("dual_pulses", 16'(n_pulse - p0), 16'd1);
        keys[0] = 1'b0;
        cyc(16);
        check("partial_pulses", 16'(n_pulse - p0), 16'd1);
        cyc(80);
        check("rescan_code", {12'h0, key_code}, 16'h0007);
        check("rescan_pulses", 16'(n_pulse - p0), 16'd2);
        keys = 16'h0000;
        cyc(40);

        // Reset during debounce count 2
        do_reset();
        p0 = n_pulse;
        keys[0] = 1'b1;
        cyc(12);
        reset = 1'b1;
        #1;
        check("abort_valid", {15'h0, key_valid}, 16'h0);
        check("abort_held", {15'h0, key_held}, 16'h0);
        check("abort_code", {12'h0, key_code}, 16'h0);
        check("abort_col", {12'h0, col_n}, 16'h000E);
        keys = 16'h0000;
        cyc(3);
        reset = 1'b0;
        cyc(24);
        check("abort_pulses", 16'(n_pulse - p0), 16'd0);

`ifdef KEYPAD_ENTRY_EN
        do_reset();
        press_key(0, 0); press_key(0, 1); press_key(0, 2); press_key(1, 0);
        check("entry_1234", entry_value, 16'h1234);
        press_key(1, 1);
        check("entry_2345", entry_value, 16'h2345);
        press_key(0, 3);
        check("entry_A", entry_value, 16'h2345);
        press_key(2, 3);
        check("entry_C", entry_value, 16'h0000);
`endif

        // Randomized presses, bounces, multi-key chords and occasional resets
        do_reset();
        for (int it = 0; it < 80; it++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            keys = 16'h0000;
            keys[$urandom_range(0, 15)] = 1'b1;
            if (mode >= 8) keys[$urandom_range(0, 15)] = 1'b1;
            if (mode <= 2) cyc(SD * int'($urandom_range(1, 2)));
            else           cyc(SD * int'($urandom_range(3, 14)));
            if (mode == 5) keys[$urandom_range(0, 15)] = 1'b0;
            cyc(SD * int'($urandom_range(0, 3)));
            keys = 16'h0000;
            cyc(SD * int'($urandom_range(1, 10)) + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 14) == 0) do_reset();
        end
        cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
